// File: rtl/adc_pkg.sv
// Shared definitions for the ADC block-averaging controller: FSM state
// encoding, default sizing constants and the accumulator-width helper.
package adc_pkg;

   localparam int DEF_SAMPLE_WIDTH = 12;
   localparam int DEF_LOG2_SAMPLES = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } adc_state_e;

   // A full block of 2^log2_samples maximum-value samples fits exactly, so
   // the accumulator can never wrap.
   function automatic int acc_width(input int sample_width, input int log2_samples);
      return sample_width + log2_samples;
   endfunction

endpackage

// File: rtl/adc_avg_controller_if.sv
// Conversion handshake between the averaging controller (master) and the
// ADC front end (slave).
interface adc_avg_controller_if
   import adc_pkg::*;
#(
   parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH
) ();

   logic                    conv_req;
   logic                    conv_done;
   logic [SAMPLE_WIDTH-1:0] conv_data;

   modport master (
      output conv_req,
      input  conv_done,
      input  conv_data
   );

   modport slave (
      input  conv_req,
      output conv_done,
      output conv_data
   );

endinterface

// File: rtl/adc_timeout_counter.sv
// Watchdog for a pending ADC conversion. Only compiled when
// ADC_AVG_TIMEOUT_EN is defined.
`ifdef ADC_AVG_TIMEOUT_EN
module adc_timeout_counter #(
   parameter int LIMIT = 1023
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam int            CW   = (LIMIT < 2) ? 1 : $clog2(LIMIT);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt;

   // Fires on the last counted cycle, so the caller spends exactly LIMIT
   // cycles waiting before it gives up.
   assign expired = count && (cnt == LAST);

   // Cycle counter: restarts from zero every time counting stops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (count) begin
         cnt <= cnt + ONE;
      end
   end

endmodule
`endif

// File: rtl/adc_avg_controller.sv
// ADC conversion sequencer and power-of-two block averager.
// Requests one conversion at a time, accumulates 2^LOG2_SAMPLES results and
// publishes the truncated mean with a single-cycle avg_valid strobe.
// Optional feature macro: ADC_AVG_TIMEOUT_EN adds a conv_done watchdog
// (TIMEOUT_CYCLES parameter, sticky timeout_err output).
module adc_avg_controller
   import adc_pkg::*;
#(
   parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
   parameter int LOG2_SAMPLES = DEF_LOG2_SAMPLES
`ifdef ADC_AVG_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1023
`endif
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    flush,
   adc_avg_controller_if.master    adc,
   output logic [SAMPLE_WIDTH-1:0] avg_out,
   output logic                    avg_valid,
   output logic [LOG2_SAMPLES-1:0] sample_cnt,
   output logic                    busy
`ifdef ADC_AVG_TIMEOUT_EN
   ,
   output logic                    timeout_err
`endif
);

   localparam int                      ACC_W   = acc_width(SAMPLE_WIDTH, LOG2_SAMPLES);
   localparam logic [LOG2_SAMPLES-1:0] CNT_ONE = LOG2_SAMPLES'(1);
   localparam logic [LOG2_SAMPLES-1:0] CNT_MAX = '1;

   adc_state_e       state;
   adc_state_e       state_next;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;
   logic             discard_pending;
   logic             take_sample;
   logic             last_sample;
   logic             timeout_hit;

   // Running sum including the sample on the bus; used both for ordinary
   // accumulation and for the final average so the last sample is counted.
   assign acc_sum = acc + {{LOG2_SAMPLES{1'b0}}, adc.conv_data};

   // A result is kept only if no flush lands on the same edge and no earlier
   // flush has marked the in-flight conversion as stale.
   assign take_sample = (state == WAIT) && adc.conv_done && !flush && !discard_pending;
   assign last_sample = take_sample && (sample_cnt == CNT_MAX);

   assign busy = (state != IDLE);

`ifdef ADC_AVG_TIMEOUT_EN
   logic expired;

   adc_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state != WAIT),
      .count   (state == WAIT),
      .expired (expired)
   );

   // A result arriving on the expiry edge still wins over the timeout.
   assign timeout_hit = expired && !adc.conv_done;

   // Sticky timeout flag; flush acknowledges it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timeout_err <= 1'b0;
      end else if (flush) begin
         timeout_err <= 1'b0;
      end else if (timeout_hit) begin
         timeout_err <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state decode for the conversion sequencer.
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (enable) state_next = WAIT;
         end
         WAIT: begin
            // Freeze is honoured only after the pending conversion resolves.
            if (adc.conv_done) begin
               state_next = last_sample ? DONE : GAP;
            end else if (timeout_hit) begin
               state_next = GAP;
            end
         end
         GAP, DONE: begin
            state_next = enable ? WAIT : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register; conv_req is registered from the next state so it is
   // glitch-free and high exactly while the FSM sits in WAIT.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         adc.conv_req <= 1'b0;
      end else begin
         state        <= state_next;
         adc.conv_req <= (state_next == WAIT);
      end
   end

   // Accumulator, sample counter and published average. The block is
   // cleared on the edge that completes it, so DONE already shows an empty
   // block and a coincident flush has nothing further to clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc        <= '0;
         sample_cnt <= '0;
         avg_out    <= '0;
         avg_valid  <= 1'b0;
      end else begin
         avg_valid <= last_sample;
         if (last_sample) begin
            avg_out <= acc_sum[ACC_W-1:LOG2_SAMPLES];
         end
         if (flush || last_sample) begin
            acc        <= '0;
            sample_cnt <= '0;
         end else if (take_sample) begin
            acc        <= acc_sum;
            sample_cnt <= sample_cnt + CNT_ONE;
         end
      end
   end

   // Marks a conversion that was flushed while in flight; its result must be
   // swallowed when the ADC finally answers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         discard_pending <= 1'b0;
      end else if ((state == WAIT) && (adc.conv_done || timeout_hit)) begin
         discard_pending <= 1'b0;
      end else if ((state == WAIT) && flush) begin
         discard_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adc_avg_controller.sv
// Directed bench for adc_avg_controller with a 4-sample block and an ADC
// model that answers three cycles after each request.
module tb_adc_avg_controller;
   import adc_pkg::*;

   localparam int SW = 12;
   localparam int L2 = 2;
`ifdef ADC_AVG_TIMEOUT_EN
   localparam int TO = 10;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic          flush;
   logic [SW-1:0] avg_out;
   logic          avg_valid;
   logic [L2-1:0] sample_cnt;
   logic          busy;
`ifdef ADC_AVG_TIMEOUT_EN
   logic          timeout_err;
`endif

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [SW-1:0] samples[$];
   bit            adc_mute = 1'b0;
   int            age = 0;

   adc_avg_controller_if #(.SAMPLE_WIDTH(SW)) adc ();

   adc_avg_controller #(
      .SAMPLE_WIDTH   (SW),
      .LOG2_SAMPLES   (L2)
`ifdef ADC_AVG_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (TO)
`endif
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .flush       (flush),
      .adc         (adc),
      .avg_out     (avg_out),
      .avg_valid   (avg_valid),
      .sample_cnt  (sample_cnt),
      .busy        (busy)
`ifdef ADC_AVG_TIMEOUT_EN
      ,
      .timeout_err (timeout_err)
`endif
   );

   always #5 clk = ~clk;

   // ADC model: answers on the third cycle of a request, driven on the
   // falling edge so the controller sees stable inputs at the rising edge.
   always @(negedge clk) begin
      if (adc.conv_req !== 1'b1) age = 0;
      else                       age = age + 1;
      if (adc.conv_req === 1'b1 && age == 3 && !adc_mute) begin
         adc.conv_done = 1'b1;
         if (samples.size() > 0) adc.conv_data = samples.pop_front();
         else                    adc.conv_data = '0;
      end else begin
         adc.conv_done = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Waits for the average strobe, checks the published value, then freezes
   // so the next block starts from a known point.
   task automatic wait_block(input string tag, input logic [SW-1:0] exp_avg);
      bit seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (avg_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, " avg_valid seen"}, 32'(seen), 32'd1);
      check({tag, " avg_out"}, 32'(avg_out), 32'(exp_avg));
      check({tag, " sample_cnt cleared"}, 32'(sample_cnt), 32'd0);
      enable = 1'b0;
      @(negedge clk);
      check({tag, " avg_valid one cycle"}, 32'(avg_valid), 32'd0);
      check({tag, " avg_out held"}, 32'(avg_out), 32'(exp_avg));
   endtask

   task automatic wait_cnt(input string tag, input logic [L2-1:0] value);
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sample_cnt === value) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, " sample_cnt reached"}, 32'(seen), 32'd1);
   endtask

   task automatic wait_req(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (adc.conv_req === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, " conv_req seen"}, 32'(seen), 32'd1);
   endtask

   initial begin
      reset_n = 1'b0;
      enable  = 1'b0;
      flush   = 1'b0;
      repeat (3) @(negedge clk);
      check("reset conv_req", 32'(adc.conv_req), 32'd0);
      check("reset avg_out", 32'(avg_out), 32'd0);
      check("reset avg_valid", 32'(avg_valid), 32'd0);
      check("reset sample_cnt", 32'(sample_cnt), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle busy", 32'(busy), 32'd0);

      // Basic block: (100+200+300+400)/4 = 250, one-cycle request latency.
      samples = '{12'd100, 12'd200, 12'd300, 12'd400};
      enable = 1'b1;
      check("basic conv_req before edge", 32'(adc.conv_req), 32'd0);
      @(posedge clk);
      #1;
      check("basic conv_req after edge", 32'(adc.conv_req), 32'd1);
      check("basic busy", 32'(busy), 32'd1);
      wait_block("basic", 12'd250);

      // Truncation: 5/4 -> 1.
      samples = '{12'd1, 12'd1, 12'd1, 12'd2};
      enable = 1'b1;
      wait_block("trunc", 12'd1);

      // Full-scale block must not overflow: 4*4095/4 = 4095.
      samples = '{12'd4095, 12'd4095, 12'd4095, 12'd4095};
      enable = 1'b1;
      wait_block("fullscale", 12'd4095);

      // Freeze during a pending conversion: third sample still lands.
      samples = '{12'd100, 12'd200, 12'd300, 12'd400};
      enable = 1'b1;
      wait_cnt("freeze", 2'd2);
      @(negedge clk);
      check("freeze wait pending", 32'(adc.conv_req), 32'd1);
      enable = 1'b0;
      repeat (8) @(negedge clk);
      check("freeze conv_req", 32'(adc.conv_req), 32'd0);
      check("freeze busy", 32'(busy), 32'd0);
      check("freeze sample_cnt", 32'(sample_cnt), 32'd3);
      check("freeze avg_out held", 32'(avg_out), 32'd4095);
      enable = 1'b1;
      wait_block("freeze resume", 12'd250);

      // Flush between conversions: 100 and 200 are dropped, 4x40 -> 40.
      samples = '{12'd100, 12'd200, 12'd40, 12'd40, 12'd40, 12'd40};
      enable = 1'b1;
      wait_cnt("flush gap", 2'd2);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush gap sample_cnt", 32'(sample_cnt), 32'd0);
      check("flush gap avg_out held", 32'(avg_out), 32'd250);
      wait_block("flush gap", 12'd40);

      // Flush while a conversion is in flight: its result (500) is dropped.
      samples = '{12'd500, 12'd8, 12'd8, 12'd8, 12'd8};
      enable = 1'b1;
      wait_req("flush wait");
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush wait conv_req held", 32'(adc.conv_req), 32'd1);
      check("flush wait sample_cnt", 32'(sample_cnt), 32'd0);
      wait_block("flush wait", 12'd8);

      // Asynchronous reset in the middle of WAIT.
      samples = '{12'd100, 12'd200, 12'd300, 12'd400};
      enable = 1'b1;
      wait_req("reset mid");
      #2;
      reset_n = 1'b0;
      #1;
      check("reset mid conv_req", 32'(adc.conv_req), 32'd0);
      check("reset mid avg_out", 32'(avg_out), 32'd0);
      check("reset mid busy", 32'(busy), 32'd0);
      @(negedge clk);
      samples.delete();
      samples = '{12'd100, 12'd200, 12'd300, 12'd400};
      reset_n = 1'b1;
      wait_block("after reset", 12'd250);

`ifdef ADC_AVG_TIMEOUT_EN
      // Silent ADC: request drops after TO cycles, flag set, count unchanged.
      begin
         int req_cycles = 0;
         check("timeout err clear", 32'(timeout_err), 32'd0);
         adc_mute = 1'b1;
         enable = 1'b1;
         for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (adc.conv_req === 1'b1) req_cycles++;
            else if (req_cycles > 0) break;
         end
         enable = 1'b0;
         check("timeout req cycles", 32'(req_cycles), 32'(TO));
         check("timeout err set", 32'(timeout_err), 32'd1);
         check("timeout sample_cnt", 32'(sample_cnt), 32'd0);
         @(negedge clk);
         check("timeout err sticky", 32'(timeout_err), 32'd1);
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
         check("timeout err flushed", 32'(timeout_err), 32'd0);
         adc_mute = 1'b0;
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
